// File: rtl/cpu_defs.sv
// cpu_defs: shared FSM state type and width constants for the expand_bit block
package cpu_defs;
  typedef enum logic [1:0] {EXP_IDLE, EXP_GEN, EXP_DONE} expand_state_t;
  localparam int EXP_LANES = 4;
  localparam int EXP_MAX_COUNT = 32;
endpackage

// File: rtl/expand_bit_byte.sv
// expand_bit_byte: one byte lane with i_r leading i_pol bits (0..8), the rest ~i_pol
module expand_bit_byte (
  input  logic       i_pol,
  input  logic [3:0] i_r,
  output logic [7:0] o_byte
);
  logic [7:0] w_tail;
  assign w_tail = 8'hFF >> i_r;
  assign o_byte = i_pol ? ~w_tail : w_tail;
endmodule

// File: rtl/expand_bit.sv
// expand_bit: byte-serial builder of a 32-bit word with count leading bit_val bits
module expand_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        bit_val,
  input  logic [5:0]  count,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] value,
  output logic        busy
);
  import cpu_defs::*;
  expand_state_t r_state, w_state_nxt;
  logic [6:0]  r_rem, w_sat;
  logic [1:0]  r_lane;
  logic        r_pol;
  logic [31:0] r_value, w_value_nxt;
  logic [3:0]  w_r;
  logic [7:0]  w_byte;
  logic        w_last;
  assign w_sat = (count > 6'(EXP_MAX_COUNT)) ? 7'(EXP_MAX_COUNT) : {1'b0, count};
  assign w_r = (r_rem >= 7'd8) ? 4'd8 : r_rem[3:0];
  assign w_last = (w_r != 4'd8) || (r_lane == 2'd0);
  expand_bit_byte u_byte (.i_pol(r_pol), .i_r(w_r), .o_byte(w_byte));
  always_comb begin
    w_value_nxt = r_value;
    for (int i = 0; i < EXP_LANES; i++)
      if (i == int'(r_lane)) w_value_nxt[i*8 +: 8] = w_byte;
      else if (w_last && i < int'(r_lane)) w_value_nxt[i*8 +: 8] = {8{~r_pol}};
  end
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = flush ? EXP_IDLE :
                  (r_state == EXP_IDLE) ? (req_valid ? EXP_GEN : EXP_IDLE) :
                  (r_state == EXP_GEN)  ? (w_last ? EXP_DONE : EXP_GEN) :
                  (resp_ready ? EXP_IDLE : EXP_DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EXP_IDLE;
      r_rem   <= '0;
      r_lane  <= '0;
      r_pol   <= 1'b0;
      r_value <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!flush && r_state == EXP_IDLE && req_valid) begin
        r_rem   <= w_sat;
        r_pol   <= bit_val;
        r_lane  <= 2'd3;
        r_value <= '0;
      end else if (!flush && r_state == EXP_GEN) begin
        r_rem   <= r_rem - {3'b0, w_r};
        r_lane  <= r_lane - 2'd1;
        r_value <= w_value_nxt;
      end
    end
  end
  assign req_ready  = (r_state == EXP_IDLE);
  assign resp_valid = (r_state == EXP_DONE);
  assign busy       = (r_state != EXP_IDLE);
  assign value      = r_value;
endmodule

// File: tb/tb_expand_bit.sv
// tb_expand_bit: randomized self-checking bench for expand_bit against a bit-level model
module tb_expand_bit;
  logic        clk = 0, rst = 1, flush = 0, req_valid = 0, bit_val = 0, resp_ready = 0;
  logic [5:0]  count = 0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] value, got;
  int checks = 0, failures = 0;

  expand_bit dut (.clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
                  .bit_val(bit_val), .count(count), .resp_valid(resp_valid), .resp_ready(resp_ready),
                  .value(value), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int c);
    return c > 32 ? 32 : c;
  endfunction

  function automatic logic [31:0] model(input logic pol, input int c);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[31-i] = (i < sat(c)) ? pol : ~pol;
    return m;
  endfunction

  function automatic int lead(input logic [31:0] v, input logic pol);
    int n = 0;
    while (n < 32 && v[31-n] == pol) n++;
    return n;
  endfunction

  function automatic int gen_cycles(input int c);
    int g = sat(c) / 8 + 1;
    return g > 4 ? 4 : g;
  endfunction

  task automatic start(input logic pol, input int c);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1; bit_val = pol; count = 6'(c);
    tick;
    req_valid = 0; bit_val = 1'($urandom); count = 6'($urandom);
    chk("gen_busy", {31'b0, busy}, 32'd1);
    chk("gen_req_ready", {31'b0, req_ready}, 32'd0);
    chk("gen_value_cleared", value, 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!resp_valid && n < 10) begin tick; n++; end
  endtask

  task automatic run(input logic pol, input int c, input int hold, output logic [31:0] v);
    int n;
    logic [31:0] exp_v;
    exp_v = model(pol, c);
    start(pol, c);
    wait_done(n);
    chk("latency", n, gen_cycles(c));
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_busy", {31'b0, busy}, 32'd1);
    end
    chk("value", value, exp_v);
    chk("roundtrip", lead(value, pol), sat(c));
    v = value;
    resp_ready = 1;
    tick;
    resp_ready = 0;
    chk("post_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] keep;
    tick; tick;
    rst = 0;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_value", value, 32'd0);

    run(0, 0, 0, got);  chk("d_c0_p0", got, 32'hFFFF_FFFF);
    run(1, 5, 0, got);  chk("d_c5_p1", got, 32'hF800_0000);
    run(0, 17, 0, got); chk("d_c17_p0", got, 32'h0000_7FFF);
    run(1, 8, 0, got);  chk("d_c8_p1", got, 32'hFF00_0000);
    run(1, 32, 0, got); chk("d_c32_p1", got, 32'hFFFF_FFFF);
    run(1, 45, 0, got); chk("d_c45_p1", got, 32'hFFFF_FFFF);
    run(0, 24, 3, got); chk("d_c24_p0", got, 32'h0000_00FF);

    start(1, 17);
    wait_done(n);
    chk("fl_lat", n, 3);
    keep = value;
    flush = 1; resp_ready = 1;
    tick;
    flush = 0; resp_ready = 0;
    chk("fl_done_valid", {31'b0, resp_valid}, 32'd0);
    chk("fl_done_req_ready", {31'b0, req_ready}, 32'd1);
    chk("fl_done_busy", {31'b0, busy}, 32'd0);
    chk("fl_value_kept", value, keep);

    start(0, 32);
    flush = 1;
    tick;
    flush = 0;
    chk("fl_gen_busy", {31'b0, busy}, 32'd0);
    chk("fl_gen_req_ready", {31'b0, req_ready}, 32'd1);

    req_valid = 1; flush = 1; bit_val = 1; count = 6'd3;
    tick;
    req_valid = 0; flush = 0;
    chk("fl_req_dropped", {31'b0, busy}, 32'd0);
    tick;
    chk("fl_req_no_resp", {31'b0, resp_valid}, 32'd0);

    start(1, 32);
    tick;
    rst = 1;
    tick;
    rst = 0;
    chk("rst_gen_value", value, 32'd0);
    chk("rst_gen_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_gen_busy", {31'b0, busy}, 32'd0);

    for (int c = 0; c <= 32; c++) begin
      run(0, c, 0, got);
      run(1, c, 0, got);
    end

    for (int k = 0; k < 40; k++)
      run(1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 2)), got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
